ikaopm_timing_gen: RTL and testbench



---
 rtl/ikaopm_timing_gen.sv | 126 ++++++++++++
 tb/tb_ikaopm_timing_gen.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ikaopm_timing_gen.sv
// Master timing generator: phiM/phi1 clock-enable strobes and the 32-slot operator counter.
// Define IKAOPM_TIMING_STALL_EN to add the i_STALL input that freezes all timing.
module ikaopm_timing_gen #(
    parameter int CLKDIV    = 4,
    parameter int SLOTS     = 32,
    parameter int SLOT_BITS = 5
) (
    input  logic                 i_EMUCLK,
    input  logic                 i_RST,
    input  logic                 i_EN,
    input  logic                 i_RESYNC,
`ifdef IKAOPM_TIMING_STALL_EN
    input  logic                 i_STALL,
`endif
    output logic                 o_PHIM_PCEN_n,
    output logic                 o_PCEN_n,
    output logic                 o_NCEN_n,
    output logic [SLOT_BITS-1:0] o_SLOT,
    output logic                 o_CYCLE_LAST,
    output logic                 o_RUNNING
);

    localparam int                   PRE_BITS  = $clog2(CLKDIV);
    localparam logic [PRE_BITS-1:0]  PRE_LAST  = PRE_BITS'(CLKDIV - 1);
    localparam logic [SLOT_BITS-1:0] SLOT_LAST = SLOT_BITS'(SLOTS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [PRE_BITS-1:0]  prescaler;
    logic                 phase;
    logic                 resync_pending;
    logic [SLOT_BITS-1:0] slot;
    logic                 stall;
    logic                 tick;
    logic                 emit;
    logic                 slot_update;

`ifdef IKAOPM_TIMING_STALL_EN
    assign stall = i_STALL;
`else
    assign stall = 1'b0;
`endif

    // A stalled prescaler never ticks, so strobes, phase, slot and the PRIME exit all freeze together.
    assign tick        = (state != IDLE) && !stall && (prescaler == PRE_LAST);
    assign emit        = (state == RUN) || (state == STOP);
    assign slot_update = tick && emit && phase;

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_EN)             state_nxt = PRIME;
            PRIME:   if (tick && phase)    state_nxt = RUN;
            RUN:     if (!i_EN)            state_nxt = STOP;
            STOP:    if (slot_update)      state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            prescaler      <= '0;
            phase          <= 1'b0;
            resync_pending <= 1'b0;
            slot           <= SLOT_LAST;
            o_PHIM_PCEN_n  <= 1'b1;
            o_PCEN_n       <= 1'b1;
            o_NCEN_n       <= 1'b1;
        end else begin
            o_PHIM_PCEN_n <= !(tick && emit);
            o_NCEN_n      <= !(tick && emit && !phase);
            o_PCEN_n      <= !slot_update;

            if (state == IDLE) begin
                prescaler      <= '0;
                resync_pending <= 1'b0;
                if (i_EN) begin
                    slot  <= SLOT_LAST;
                    phase <= 1'b0;
                end
            end else begin
                if (tick) begin
                    prescaler <= '0;
                    phase     <= ~phase;
                end else if (!stall) begin
                    prescaler <= prescaler + PRE_BITS'(1);
                end

                // Resync requests arriving before the strobes start are meaningless and dropped.
                if (state == PRIME || slot_update) begin
                    resync_pending <= 1'b0;
                end else if (i_RESYNC) begin
                    resync_pending <= 1'b1;
                end

                if (slot_update) begin
                    if (resync_pending || i_RESYNC || slot == SLOT_LAST) begin
                        slot <= '0;
                    end else begin
                        slot <= slot + SLOT_BITS'(1);
                    end
                end
            end
        end
    end

    assign o_SLOT       = slot;
    assign o_RUNNING    = (state == RUN);
    assign o_CYCLE_LAST = o_RUNNING && (slot == SLOT_LAST);

endmodule

// File: tb/tb_ikaopm_timing_gen.sv
// Self-checking bench for ikaopm_timing_gen: start-up latency, slot wrap, resync, stop, stall and reset.
module tb_ikaopm_timing_gen;

    localparam int CLKDIV    = 4;
    localparam int SLOTS     = 32;
    localparam int SLOT_BITS = 5;
    localparam logic [SLOT_BITS-1:0] SLOT_LAST = SLOT_BITS'(SLOTS - 1);

    logic i_EMUCLK = 1'b0;
    logic i_RST    = 1'b1;
    logic i_EN     = 1'b0;
    logic i_RESYNC = 1'b0;
`ifdef IKAOPM_TIMING_STALL_EN
    logic i_STALL  = 1'b0;
`endif
    logic                 o_PHIM_PCEN_n;
    logic                 o_PCEN_n;
    logic                 o_NCEN_n;
    logic [SLOT_BITS-1:0] o_SLOT;
    logic                 o_CYCLE_LAST;
    logic                 o_RUNNING;

    int checks   = 0;
    int failures = 0;
    logic [SLOT_BITS-1:0] exp_q[$];

    ikaopm_timing_gen #(
        .CLKDIV    (CLKDIV),
        .SLOTS     (SLOTS),
        .SLOT_BITS (SLOT_BITS)
    ) dut (
        .i_EMUCLK      (i_EMUCLK),
        .i_RST         (i_RST),
        .i_EN          (i_EN),
        .i_RESYNC      (i_RESYNC),
`ifdef IKAOPM_TIMING_STALL_EN
        .i_STALL       (i_STALL),
`endif
        .o_PHIM_PCEN_n (o_PHIM_PCEN_n),
        .o_PCEN_n      (o_PCEN_n),
        .o_NCEN_n      (o_NCEN_n),
        .o_SLOT        (o_SLOT),
        .o_CYCLE_LAST  (o_CYCLE_LAST),
        .o_RUNNING     (o_RUNNING)
    );

    always #5 i_EMUCLK = ~i_EMUCLK;

    task automatic step;
        @(posedge i_EMUCLK);
        #1;
    endtask

    // Steps until the chosen phi1 strobe is low; n is the step count, or -1 when the budget runs out.
    task automatic wait_strobe(input bit want_pcen, input int budget, output int n);
        n = -1;
        for (int c = 1; c <= budget; c++) begin
            step;
            if (want_pcen ? !o_PCEN_n : !o_NCEN_n) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic wait_slot(input logic [SLOT_BITS-1:0] target);
        bit found = 0;
        for (int c = 0; c < SLOTS * 2 * CLKDIV + 32; c++) begin
            step;
            if (!o_PCEN_n && o_SLOT == target) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("[TB] FAIL wait_slot timeout target=%0d last_slot=%0d", target, o_SLOT);
        end
    endtask

    task automatic test_reset;
        i_RST = 1'b1; i_EN = 1'b0; i_RESYNC = 1'b0;
        step; step;
        checks++; if (o_PHIM_PCEN_n !== 1'b1) begin failures++; $display("[TB] FAIL reset_phim got=%b want=1", o_PHIM_PCEN_n); end
        checks++; if (o_PCEN_n !== 1'b1) begin failures++; $display("[TB] FAIL reset_pcen got=%b want=1", o_PCEN_n); end
        checks++; if (o_NCEN_n !== 1'b1) begin failures++; $display("[TB] FAIL reset_ncen got=%b want=1", o_NCEN_n); end
        checks++; if (o_SLOT !== SLOT_LAST) begin failures++; $display("[TB] FAIL reset_slot got=%0d want=%0d", o_SLOT, SLOT_LAST); end
        checks++; if (o_CYCLE_LAST !== 1'b0) begin failures++; $display("[TB] FAIL reset_last got=%b want=0", o_CYCLE_LAST); end
        checks++; if (o_RUNNING !== 1'b0) begin failures++; $display("[TB] FAIL reset_running got=%b want=0", o_RUNNING); end
        i_RST = 1'b0;
        step;
        checks++; if (o_RUNNING !== 1'b0 || o_PHIM_PCEN_n !== 1'b1) begin failures++; $display("[TB] FAIL idle_hold running=%b phim=%b want 0/1", o_RUNNING, o_PHIM_PCEN_n); end
    endtask

    task automatic test_start;
        logic exp_run, exp_phim, exp_ncen, exp_pcen;
        logic [SLOT_BITS-1:0] exp_slot;
        i_EN = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            step;
            exp_run  = (k >= 8);
            exp_phim = !(k >= 12 && (k % 4) == 0);
            exp_ncen = (k != 12);
            exp_pcen = (k != 16);
            exp_slot = (k == 16) ? SLOT_BITS'(0) : SLOT_LAST;
            checks++; if (o_RUNNING !== exp_run) begin failures++; $display("[TB] FAIL start_running edge=%0d got=%b want=%b", k, o_RUNNING, exp_run); end
            checks++; if (o_PHIM_PCEN_n !== exp_phim) begin failures++; $display("[TB] FAIL start_phim edge=%0d got=%b want=%b", k, o_PHIM_PCEN_n, exp_phim); end
            checks++; if (o_NCEN_n !== exp_ncen) begin failures++; $display("[TB] FAIL start_ncen edge=%0d got=%b want=%b", k, o_NCEN_n, exp_ncen); end
            checks++; if (o_PCEN_n !== exp_pcen) begin failures++; $display("[TB] FAIL start_pcen edge=%0d got=%b want=%b", k, o_PCEN_n, exp_pcen); end
            checks++; if (o_SLOT !== exp_slot) begin failures++; $display("[TB] FAIL start_slot edge=%0d got=%0d want=%0d", k, o_SLOT, exp_slot); end
        end
    endtask

    task automatic test_wrap;
        logic [SLOT_BITS-1:0] exp_slot = '0;
        int gap = 0;
        int last_cycles = 0;
        for (int s = 1; s <= SLOTS; s++) exp_q.push_back(SLOT_BITS'(s % SLOTS));
        for (int c = 0; c < SLOTS * 2 * CLKDIV + 8 && exp_q.size() > 0; c++) begin
            step;
            gap++;
            if (!o_PCEN_n) begin
                exp_slot = exp_q.pop_front();
                checks++; if (gap != 2 * CLKDIV) begin failures++; $display("[TB] FAIL wrap_period got=%0d want=%0d", gap, 2 * CLKDIV); end
                gap = 0;
            end
            checks++; if (o_SLOT !== exp_slot) begin failures++; $display("[TB] FAIL wrap_slot got=%0d want=%0d", o_SLOT, exp_slot); end
            checks++; if (o_CYCLE_LAST !== (exp_slot == SLOT_LAST)) begin failures++; $display("[TB] FAIL wrap_last slot=%0d got=%b want=%b", exp_slot, o_CYCLE_LAST, exp_slot == SLOT_LAST); end
            checks++; if (!o_PCEN_n && !o_NCEN_n) begin failures++; $display("[TB] FAIL wrap_overlap pcen=%b ncen=%b want not both 0", o_PCEN_n, o_NCEN_n); end
            if (o_CYCLE_LAST) last_cycles++;
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL wrap_timeout pending=%0d want=0", exp_q.size()); end
        exp_q.delete();
        checks++; if (last_cycles != 2 * CLKDIV) begin failures++; $display("[TB] FAIL wrap_last_len got=%0d want=%0d", last_cycles, 2 * CLKDIV); end
    endtask

    task automatic test_resync;
        int n;
        logic [SLOT_BITS-1:0] exp_slot;
        wait_slot(SLOT_BITS'(10));
        i_RESYNC = 1'b1; step; i_RESYNC = 1'b0;
        exp_q.push_back('0);
        wait_strobe(1'b1, 4 * CLKDIV, n);
        exp_slot = exp_q.pop_front();
        checks++; if (n != 2 * CLKDIV - 1 || o_SLOT !== exp_slot) begin failures++; $display("[TB] FAIL resync_early steps=%0d slot=%0d want steps=%0d slot=%0d", n, o_SLOT, 2 * CLKDIV - 1, exp_slot); end
        for (int c = 0; c < 2 * CLKDIV - 1; c++) step;
        i_RESYNC = 1'b1; step; i_RESYNC = 1'b0;
        exp_q.push_back('0);
        exp_slot = exp_q.pop_front();
        checks++; if (o_PCEN_n !== 1'b0 || o_SLOT !== exp_slot) begin failures++; $display("[TB] FAIL resync_coincident pcen=%b slot=%0d want pcen=0 slot=%0d", o_PCEN_n, o_SLOT, exp_slot); end
        exp_q.push_back(SLOT_BITS'(1));
        wait_strobe(1'b1, 4 * CLKDIV, n);
        exp_slot = exp_q.pop_front();
        checks++; if (n < 0 || o_SLOT !== exp_slot) begin failures++; $display("[TB] FAIL resync_after steps=%0d slot=%0d want slot=%0d", n, o_SLOT, exp_slot); end
    endtask

    task automatic test_stop;
        int n;
        int pcen_count = 0;
        logic exp_strobe_low;
        logic [SLOT_BITS-1:0] exp_slot;
        wait_strobe(1'b0, 4 * CLKDIV, n);
        checks++; if (n < 0) begin failures++; $display("[TB] FAIL stop_ncen_timeout steps=%0d want>0", n); end
        i_EN = 1'b0;
        exp_q.push_back(SLOT_BITS'(2));
        for (int c = 1; c <= 24; c++) begin
            step;
            exp_strobe_low = (c == CLKDIV);
            checks++; if (o_RUNNING !== 1'b0) begin failures++; $display("[TB] FAIL stop_running cyc=%0d got=%b want=0", c, o_RUNNING); end
            checks++; if (o_PCEN_n !== !exp_strobe_low || o_PHIM_PCEN_n !== !exp_strobe_low || o_NCEN_n !== 1'b1) begin
                failures++; $display("[TB] FAIL stop_strobes cyc=%0d pcen=%b phim=%b ncen=%b want %b/%b/1", c, o_PCEN_n, o_PHIM_PCEN_n, o_NCEN_n, !exp_strobe_low, !exp_strobe_low);
            end
            if (!o_PCEN_n) begin
                pcen_count++;
                if (exp_q.size() > 0) begin
                    exp_slot = exp_q.pop_front();
                    checks++; if (o_SLOT !== exp_slot) begin failures++; $display("[TB] FAIL stop_slot got=%0d want=%0d", o_SLOT, exp_slot); end
                end
            end
        end
        checks++; if (pcen_count != 1) begin failures++; $display("[TB] FAIL stop_pcen_count got=%0d want=1", pcen_count); end
        exp_q.delete();
        i_EN = 1'b1;
        wait_strobe(1'b1, 40, n);
        checks++; if (n != 17 || o_SLOT !== '0) begin failures++; $display("[TB] FAIL restart steps=%0d slot=%0d want steps=17 slot=0", n, o_SLOT); end
    endtask

`ifdef IKAOPM_TIMING_STALL_EN
    task automatic test_stall;
        int n;
        step; step;
        i_STALL = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step;
            checks++; if (o_PHIM_PCEN_n !== 1'b1 || o_PCEN_n !== 1'b1 || o_NCEN_n !== 1'b1 || o_SLOT !== '0) begin
                failures++; $display("[TB] FAIL stall_hold cyc=%0d phim=%b pcen=%b ncen=%b slot=%0d want 1/1/1/0", c, o_PHIM_PCEN_n, o_PCEN_n, o_NCEN_n, o_SLOT);
            end
        end
        i_STALL = 1'b0;
        step;
        checks++; if (o_PHIM_PCEN_n !== 1'b1) begin failures++; $display("[TB] FAIL stall_early_tick phim=%b want=1", o_PHIM_PCEN_n); end
        step;
        checks++; if (o_PHIM_PCEN_n !== 1'b0 || o_NCEN_n !== 1'b0 || o_PCEN_n !== 1'b1) begin failures++; $display("[TB] FAIL stall_resume phim=%b ncen=%b pcen=%b want 0/0/1", o_PHIM_PCEN_n, o_NCEN_n, o_PCEN_n); end
        exp_q.push_back(SLOT_BITS'(1));
        wait_strobe(1'b1, 4 * CLKDIV, n);
        checks++; if (n != CLKDIV || o_SLOT !== exp_q.pop_front()) begin failures++; $display("[TB] FAIL stall_slot steps=%0d slot=%0d want steps=%0d slot=1", n, o_SLOT, CLKDIV); end
    endtask
`endif

    task automatic test_reset_mid_run;
        wait_slot(SLOT_BITS'(17));
        step; step; step;
        checks++; if (o_RUNNING !== 1'b1) begin failures++; $display("[TB] FAIL midrun_running got=%b want=1", o_RUNNING); end
        i_EN = 1'b0;
        i_RST = 1'b1;
        step;
        checks++; if (o_PHIM_PCEN_n !== 1'b1 || o_PCEN_n !== 1'b1 || o_NCEN_n !== 1'b1) begin failures++; $display("[TB] FAIL midrun_strobes phim=%b pcen=%b ncen=%b want 1/1/1", o_PHIM_PCEN_n, o_PCEN_n, o_NCEN_n); end
        checks++; if (o_SLOT !== SLOT_LAST) begin failures++; $display("[TB] FAIL midrun_slot got=%0d want=%0d", o_SLOT, SLOT_LAST); end
        checks++; if (o_RUNNING !== 1'b0 || o_CYCLE_LAST !== 1'b0) begin failures++; $display("[TB] FAIL midrun_flags running=%b last=%b want 0/0", o_RUNNING, o_CYCLE_LAST); end
        i_RST = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step;
            checks++; if (o_PHIM_PCEN_n !== 1'b1 || o_PCEN_n !== 1'b1 || o_NCEN_n !== 1'b1) begin failures++; $display("[TB] FAIL midrun_stray cyc=%0d phim=%b pcen=%b ncen=%b want 1/1/1", c, o_PHIM_PCEN_n, o_PCEN_n, o_NCEN_n); end
        end
    endtask

    initial begin
        test_reset;
        test_start;
        test_wrap;
        test_resync;
        test_stop;
`ifdef IKAOPM_TIMING_STALL_EN
        test_stall;
`endif
        test_reset_mid_run;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
